poly_oscillator: RTL and testbench

POLY_OSCILLATOR -- requirements
Module: poly_oscillator

---
 rtl/poly_osc_pkg.sv | 26 ++
 rtl/sine_quarter_lut.sv | 47 ++++
 rtl/poly_oscillator.sv | 207 ++++++++++++++++++++
 tb/tb_poly_oscillator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_osc_pkg.sv
// rtl/poly_osc_pkg.sv - shared waveform/state enums and amplitude helpers for poly_oscillator
package poly_osc_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_SAW    = 2'b10,
    WAVE_TRI    = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_MIX
  } osc_state_e;

  localparam int OSC_DEFAULT_DATA_WIDTH = 24;

  // Largest positive sample for a given signed sample width.
  function automatic longint osc_max(int data_width);
    return (longint'(1) << (data_width - 1)) - 1;
  endfunction

  localparam longint OSC_MAX = osc_max(OSC_DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/sine_quarter_lut.sv
// rtl/sine_quarter_lut.sv - registered quarter-wave sine ROM, entry 0 = 0, last entry = MAX
module sine_quarter_lut
  import poly_osc_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-2:0] data
);

  localparam int     DEPTH   = 1 << ADDR_WIDTH;
  localparam int     FRAC    = 28;
  localparam longint ONE     = longint'(1) << FRAC;
  localparam longint HALF_PI = longint'(421657428);

  // Fixed-point Taylor series (Horner form, up to x^13) so the table elaborates without real math.
  function automatic logic [DATA_WIDTH-2:0] sine_entry(int idx);
    longint x, x2, t, s, v;
    x  = (HALF_PI * idx) / (DEPTH - 1);
    x2 = (x * x) >>> FRAC;
    t  = ONE;
    for (int n = 6; n >= 1; n--) begin
      t = ONE - ((x2 * t) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
    end
    s = (x * t) >>> FRAC;
    v = (s * osc_max(DATA_WIDTH) + (ONE >>> 1)) >>> FRAC;
    if (v > osc_max(DATA_WIDTH)) v = osc_max(DATA_WIDTH);
    if (v < 0) v = 0;
    return v[DATA_WIDTH-2:0];
  endfunction

  logic [DATA_WIDTH-2:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [DATA_WIDTH-2:0] ENTRY = sine_entry(i);
    assign rom[i] = ENTRY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= rom[addr];
  end

endmodule

// File: rtl/poly_oscillator.sv
// rtl/poly_oscillator.sv - time-multiplexed polyphonic oscillator with mixer; POLY_OSC_PWM_EN adds pulse_width
module poly_oscillator
  import poly_osc_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int NUM_VOICES     = 8,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     step_in,
  input  logic [NUM_VOICES-1:0]                    voice_en,
  input  logic [NUM_VOICES-1:0]                    phase_rst,
  input  logic [NUM_VOICES*PHASE_WIDTH-1:0]        phase_incr,
  input  logic [2*NUM_VOICES-1:0]                  wave_type,
`ifdef POLY_OSC_PWM_EN
  input  logic [8*NUM_VOICES-1:0]                  pulse_width,
`endif
  output logic [DATA_WIDTH-1:0]                    voice_data,
  output logic [$clog2(NUM_VOICES)-1:0]            voice_idx,
  output logic                                     voice_valid,
  output logic [DATA_WIDTH+$clog2(NUM_VOICES)-1:0] mix_out,
  output logic                                     mix_valid,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = IW + 2;
  localparam int MW = DATA_WIDTH + IW;
  localparam logic [DATA_WIDTH-1:0] MAX       = DATA_WIDTH'(osc_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] NEG_MAX   = ~MAX + DATA_WIDTH'(1);
  localparam logic [CW-1:0]         VOICE_CNT = CW'(NUM_VOICES);
  localparam logic [CW-1:0]         LAST_CNT  = CW'(NUM_VOICES + 2);

  osc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic issue, mix_fire;
  logic [IW-1:0] vidx;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE:  if (step_in) state_d = ST_SWEEP;
      ST_SWEEP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) state_d = ST_MIX;
      end
      ST_MIX:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (step_in && state_q != ST_IDLE) overrun <= 1'b1;
    end
  end

  // Counter keeps running past the last voice to cover the three-stage drain.
  assign issue    = (state_q == ST_SWEEP) && (cnt_q < VOICE_CNT);
  assign mix_fire = (state_q == ST_SWEEP) && (cnt_q == LAST_CNT);
  assign vidx     = cnt_q[IW-1:0];
  assign busy     = (state_q != ST_IDLE);

  logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] p_cur, incr_cur;

  assign incr_cur = phase_incr[vidx*PHASE_WIDTH +: PHASE_WIDTH];
  assign p_cur    = phase_rst[vidx] ? '0 : phase_q[vidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else if (issue && (voice_en[vidx] || phase_rst[vidx])) begin
      phase_q[vidx] <= p_cur + incr_cur;
    end
  end

  logic                  s1_valid, s1_en;
  logic [IW-1:0]         s1_idx;
  wave_e                 s1_wave;
  logic [DATA_WIDTH-1:0] s1_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_idx   <= '0;
      s1_wave  <= WAVE_SINE;
      s1_t     <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_en   <= voice_en[vidx];
        s1_idx  <= vidx;
        s1_wave <= wave_e'(wave_type[2*vidx +: 2]);
        s1_t    <= p_cur[PHASE_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

`ifdef POLY_OSC_PWM_EN
  logic [7:0] s1_pw;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     s1_pw <= '0;
    else if (issue) s1_pw <= pulse_width[vidx*8 +: 8];
  end
`endif

  logic [LUT_ADDR_WIDTH-1:0] lut_addr;
  logic [DATA_WIDTH-2:0]     lut_data;

  // Odd quadrants read the table backwards.
  assign lut_addr = s1_t[DATA_WIDTH-2] ? ~s1_t[DATA_WIDTH-3 -: LUT_ADDR_WIDTH]
                                       :  s1_t[DATA_WIDTH-3 -: LUT_ADDR_WIDTH];

  sine_quarter_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (LUT_ADDR_WIDTH)
  ) u_sine_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (lut_addr),
    .data  (lut_data)
  );

  logic [DATA_WIDTH-1:0] wave_val, tri_ramp;

  always_comb begin
    wave_val = '0;
    tri_ramp = {s1_t[DATA_WIDTH-2:0], 1'b0};
    case (s1_wave)
`ifdef POLY_OSC_PWM_EN
      WAVE_SQUARE: wave_val = (s1_t[DATA_WIDTH-1 -: 8] < s1_pw) ? MAX : NEG_MAX;
`else
      WAVE_SQUARE: wave_val = s1_t[DATA_WIDTH-1] ? NEG_MAX : MAX;
`endif
      WAVE_SAW:    wave_val = {~s1_t[DATA_WIDTH-1], s1_t[DATA_WIDTH-2:0]};
      WAVE_TRI:    wave_val = s1_t[DATA_WIDTH-1] ? MAX - tri_ramp : tri_ramp - MAX;
      default:     wave_val = '0;
    endcase
  end

  logic                  s2_valid, s2_en, s2_sine, s2_neg;
  logic [IW-1:0]         s2_idx;
  logic [DATA_WIDTH-1:0] s2_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_en    <= 1'b0;
      s2_sine  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_idx   <= '0;
      s2_val   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_en   <= s1_en;
        s2_sine <= (s1_wave == WAVE_SINE);
        s2_neg  <= s1_t[DATA_WIDTH-1];
        s2_idx  <= s1_idx;
        s2_val  <= wave_val;
      end
    end
  end

  logic [DATA_WIDTH-1:0] sine_val, sample;
  logic [MW-1:0]         acc_q;

  always_comb begin
    sine_val = {1'b0, lut_data};
    if (s2_neg) sine_val = -sine_val;
    sample = '0;
    if (s2_en) sample = s2_sine ? sine_val : s2_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_valid <= 1'b0;
      voice_data  <= '0;
      voice_idx   <= '0;
      acc_q       <= '0;
      mix_valid   <= 1'b0;
      mix_out     <= '0;
    end else begin
      voice_valid <= s2_valid;
      mix_valid   <= mix_fire;
      if (s2_valid) begin
        voice_data <= sample;
        voice_idx  <= s2_idx;
        acc_q      <= ((s2_idx == '0) ? {MW{1'b0}} : acc_q) + {{IW{sample[DATA_WIDTH-1]}}, sample};
      end
      if (mix_fire) mix_out <= acc_q;
    end
  end

endmodule

// File: tb/tb_poly_oscillator.sv
// tb/tb_poly_oscillator.sv - randomized self-checking bench for poly_oscillator against a phase/waveform model
module tb_poly_oscillator;

  localparam int     DW   = 24;
  localparam int     NV   = 8;
  localparam int     PW   = 32;
  localparam int     LW   = 10;
  localparam int     IW   = 3;
  localparam int     MW   = DW + IW;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint HV   = longint'(1) << (DW - 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              step_in = 1'b0;
  logic [NV-1:0]     voice_en = '0;
  logic [NV-1:0]     phase_rst = '0;
  logic [NV*PW-1:0]  phase_incr = '0;
  logic [2*NV-1:0]   wave_type = '0;
`ifdef POLY_OSC_PWM_EN
  logic [8*NV-1:0]   pulse_width = '0;
`endif
  logic [DW-1:0]     voice_data;
  logic [IW-1:0]     voice_idx;
  logic              voice_valid;
  logic [MW-1:0]     mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun;

  poly_oscillator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_in     (step_in),
    .voice_en    (voice_en),
    .phase_rst   (phase_rst),
    .phase_incr  (phase_incr),
    .wave_type   (wave_type),
`ifdef POLY_OSC_PWM_EN
    .pulse_width (pulse_width),
`endif
    .voice_data  (voice_data),
    .voice_idx   (voice_idx),
    .voice_valid (voice_valid),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mph [NV];
  longint exp_data [NV];
  bit     exp_sine [NV];
  longint got [NV];
  longint exp_mix, last_mix;
  int     nsine;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sine_ref(input logic [PW-1:0] p);
    int  j;
    real r;
    j = int'(p[PW-3 -: LW]);
    if (p[PW-2]) j = (1 << LW) - 1 - j;
    r = $sin(3.14159265358979 / 2.0 * real'(j) / real'((1 << LW) - 1));
    return p[PW-1] ? -longint'($rtoi(r * MAXV + 0.5)) : longint'($rtoi(r * MAXV + 0.5));
  endfunction

  function automatic longint model_wave(input int w, input logic [PW-1:0] p, input int pw);
    longint t;
    t = longint'(p >> (PW - DW));
    case (w)
      0: return sine_ref(p);
`ifdef POLY_OSC_PWM_EN
      1: return (int'(p >> (PW - 8)) < pw) ? MAXV : -MAXV;
`else
      1: return (longint'(p) < (longint'(1) << (PW - 1))) ? MAXV : -MAXV;
`endif
      2: return t - HV;
      default: return (t < HV) ? 2 * t - MAXV : MAXV - 2 * (t - HV);
    endcase
  endfunction

  task automatic plan_sweep();
    logic [PW-1:0] p;
    int w, pw;
    exp_mix = 0;
    nsine = 0;
    for (int v = 0; v < NV; v++) begin
      p = phase_rst[v] ? '0 : mph[v];
      w = int'(wave_type[2*v +: 2]);
`ifdef POLY_OSC_PWM_EN
      pw = int'(pulse_width[8*v +: 8]);
`else
      pw = 0;
`endif
      exp_sine[v] = voice_en[v] && (w == 0);
      exp_data[v] = voice_en[v] ? model_wave(w, p, pw) : 0;
      if (phase_rst[v] || voice_en[v]) mph[v] = p + phase_incr[v*PW +: PW];
      exp_mix += exp_data[v];
      if (exp_sine[v]) nsine++;
    end
  endtask

  // extra_at > 0 fires a second step_in at that edge of the sweep
  task automatic run_sweep(input int extra_at);
    longint d, m;
    int v;
    plan_sweep();
    step_in = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= NV + 5; k++) begin
      step_in = (k == extra_at);
      @(posedge clk); #1;
      check("busy", longint'(busy), longint'(k <= NV + 3));
      check("voice_valid", longint'(voice_valid), longint'(k >= 3 && k <= NV + 2));
      check("mix_valid", longint'(mix_valid), longint'(k == NV + 3));
      if (k >= 3 && k <= NV + 2) begin
        v = k - 3;
        d = longint'($signed(voice_data));
        got[v] = d;
        check("voice_idx", longint'(voice_idx), longint'(v));
        if (exp_sine[v]) check("sine_within_1lsb", longint'((d - exp_data[v] <= 1) && (exp_data[v] - d <= 1)), 1);
        else             check("voice_data", d, exp_data[v]);
      end
      if (k == NV + 3 || k == NV + 5) begin
        m = longint'($signed(mix_out));
        if (k == NV + 3) last_mix = m;
        if (nsine == 0) check(k == NV + 3 ? "mix_out" : "mix_hold", m, exp_mix);
        else check("mix_within_tol", longint'((m - exp_mix <= nsine) && (exp_mix - m <= nsine)), 1);
      end
    end
    step_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int v = 0; v < NV; v++) mph[v] = '0;
    @(posedge clk); #1;
  endtask

  task automatic set_all_incr(input logic [PW-1:0] incr);
    for (int v = 0; v < NV; v++) phase_incr[v*PW +: PW] = incr;
  endtask

  longint seq_sq [5];
  longint seq_sin [4];

  initial begin
    for (int v = 0; v < NV; v++) mph[v] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_voice_data", longint'(voice_data), 0);
    check("rst_mix_out", longint'(mix_out), 0);
    check("rst_voice_valid", longint'(voice_valid), 0);
    check("rst_mix_valid", longint'(mix_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", longint'(busy), 0);

    // all voices saw, incr 2^28
    voice_en = '1; wave_type = {NV{2'b10}}; set_all_incr(32'h1000_0000);
    run_sweep(0);
    run_sweep(0);
    check("saw_sweep2_v0", got[0], -longint'(32'h70_0000));

    // voice 0 square, incr 2^30, restarted on the first sweep
    seq_sq = '{MAXV, MAXV, -MAXV, -MAXV, MAXV};
    wave_type[1:0] = 2'b01; phase_incr[0 +: PW] = 32'h4000_0000;
    for (int s = 0; s < 5; s++) begin
      phase_rst = (s == 0) ? 8'h01 : 8'h00;
      run_sweep(0);
      check("square_seq", got[0], seq_sq[s]);
    end

    // voice 2 sine, incr 2^30, restarted on sweeps 1 and 4
    seq_sin = '{0, MAXV, 0, 0};
    wave_type[5:4] = 2'b00; phase_incr[2*PW +: PW] = 32'h4000_0000;
    for (int s = 0; s < 4; s++) begin
      phase_rst = (s == 0 || s == 3) ? 8'h04 : 8'h00;
      run_sweep(0);
      check("sine_seq", got[2], seq_sin[s]);
    end
    phase_rst = '0;

    // half the voices disabled, all square from phase 0
    do_reset();
    voice_en = 8'h0F; wave_type = {NV{2'b01}}; set_all_incr(32'h0123_4567);
    run_sweep(0);
    check("mix_en_0f", last_mix, 4 * MAXV);
    voice_en = '1; set_all_incr('0);
    run_sweep(0);
    check("disabled_phase_kept", got[5], MAXV);

    // step_in while busy
    check("overrun_before", longint'(overrun), 0);
    wave_type = {NV{2'b10}}; set_all_incr(32'h0800_0000);
    run_sweep(4);
    check("overrun_set", longint'(overrun), 1);
    run_sweep(NV + 4);
    check("overrun_sticky", longint'(overrun), 1);

    // randomized sweeps
    for (int s = 0; s < 20; s++) begin
      voice_en  = NV'($urandom);
      phase_rst = NV'($urandom & $urandom & $urandom);
      wave_type = (2*NV)'($urandom);
      for (int v = 0; v < NV; v++) phase_incr[v*PW +: PW] = $urandom;
`ifdef POLY_OSC_PWM_EN
      for (int v = 0; v < NV; v++) pulse_width[8*v +: 8] = 8'($urandom);
`endif
      run_sweep((s % 4 == 3) ? int'($urandom_range(1, NV + 4)) : 0);
    end

    // reset in the middle of a sweep
    voice_en = '1; wave_type = {NV{2'b01}}; phase_rst = '0;
    step_in = 1'b1;
    @(posedge clk); #1 step_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_voice_data", longint'(voice_data), 0);
    check("mid_rst_voice_idx", longint'(voice_idx), 0);
    check("mid_rst_voice_valid", longint'(voice_valid), 0);
    check("mid_rst_mix_out", longint'(mix_out), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_overrun", longint'(overrun), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int v = 0; v < NV; v++) mph[v] = '0;
    for (int k = 0; k < NV + 5; k++) begin
      @(posedge clk); #1;
      check("no_mix_after_rst", longint'(mix_valid), 0);
    end
    set_all_incr(32'h9000_0000);
    run_sweep(0);
    check("post_rst_phase0", got[7], MAXV);

`ifdef POLY_OSC_PWM_EN
    // 25 % duty square
    voice_en = '1; wave_type = {NV{2'b01}}; set_all_incr(32'h4000_0000);
    for (int v = 0; v < NV; v++) pulse_width[8*v +: 8] = 8'd64;
    for (int s = 0; s < 4; s++) begin
      phase_rst = (s == 0) ? '1 : '0;
      run_sweep(0);
      check("pwm_seq", got[0], (s == 0) ? MAXV : -MAXV);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
